// File: rtl/cnt_read_sched_if.sv
// cnt_read_sched_if: request/response bus between the sweep sequencer and the counter read mux
interface cnt_read_sched_if #(
    parameter int CW = 5,
    parameter int IW = 3
);
    logic          req;
    logic [IW-1:0] idx;
    logic          valid;
    logic [CW-1:0] data;
    modport master (output req, idx, input valid, data);
    modport slave (input req, idx, output valid, data);
endinterface

// File: rtl/cnt_read_sched.sv
// cnt_read_sched: sweeps every event counter through the read mux into one snapshot word
module cnt_read_sched #(
    parameter int          NUM_CNT   = 5,
    parameter int          CW        = 5,
    parameter int          IW        = 3,
    parameter int          TIMEOUT   = 8,
    parameter logic [3:0]  IDLE_CODE = 4'b0100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            state,
    input  logic                  start,
    cnt_read_sched_if.master      mux,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [NUM_CNT*CW-1:0] snap
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} fsm_t;

    fsm_t                  fsm, fsm_d;
    logic                  req, req_d, busy_d, done_d, err_d, main_idle;
    logic [IW-1:0]         idx, idx_d;
    logic [TW-1:0]         timer, timer_d;
    logic [NUM_CNT*CW-1:0] snap_d;

    assign main_idle = state == IDLE_CODE;
    assign mux.req   = req;
    assign mux.idx   = idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm   <= S_IDLE;
            req   <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            snap  <= '0;
            timer <= '0;
        end else begin
            fsm   <= fsm_d;
            req   <= req_d;
            idx   <= idx_d;
            busy  <= busy_d;
            done  <= done_d;
            err   <= err_d;
            snap  <= snap_d;
            timer <= timer_d;
        end
    end

    // Outputs are computed for the state being entered so that they appear registered.
    always_comb begin
        fsm_d   = fsm;
        req_d   = 1'b0;
        idx_d   = idx;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = err;
        snap_d  = snap;
        timer_d = timer == TW'(TIMEOUT - 1) ? timer : timer + TW'(1);
        case (fsm)
            S_IDLE: if (start && main_idle) begin
                fsm_d  = S_REQ;
                req_d  = 1'b1;
                idx_d  = '0;
                busy_d = 1'b1;
                err_d  = 1'b0;
                snap_d = '0;
            end
            S_REQ: begin
                fsm_d   = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: if (!main_idle) begin
                err_d = 1'b1;
                fsm_d = S_DONE;
            end else if (mux.valid) begin
                for (int i = 0; i < NUM_CNT; i++)
                    if (idx == IW'(i)) snap_d[CW*i +: CW] = mux.data;
                fsm_d = idx == IW'(NUM_CNT - 1) ? S_DONE : S_REQ;
                req_d = idx != IW'(NUM_CNT - 1);
                idx_d = idx == IW'(NUM_CNT - 1) ? idx : idx + IW'(1);
            end else if (timer == TW'(TIMEOUT - 1)) begin
                err_d = 1'b1;
                fsm_d = S_DONE;
            end
            default: begin
                fsm_d = S_IDLE;
                idx_d = '0;
            end
        endcase
        if (fsm_d == S_DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_cnt_read_sched.sv
// tb_cnt_read_sched: directed sweeps against a 1-cycle mux model, checked by an idx/snapshot scoreboard
module tb_cnt_read_sched;
    localparam logic [3:0] IDLE = 4'b0100;
    localparam logic [3:0] ACTIVE = 4'b1000;

    typedef struct {
        logic [24:0] snap;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic        start;
    logic        busy, done, err;
    logic [24:0] snap;
    logic [2:0]  stall_idx;
    logic [4:0]  tbl [0:4];
    int          cyc = 0;
    int          pass = 0;
    int          total = 0;
    exp_t        sq[$];
    int          iq[$];

    cnt_read_sched_if #(.CW(5), .IW(3)) bus ();

    cnt_read_sched dut (
        .clk(clk), .reset(reset), .state(state), .start(start), .mux(bus),
        .busy(busy), .done(done), .err(err), .snap(snap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) pass++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    // Mux model: answers one cycle after each req unless the index is stalled.
    initial begin
        logic       r;
        logic [2:0] i;
        bus.valid = 1'b0;
        bus.data  = '0;
        forever begin
            @(posedge clk);
            r = bus.req;
            i = bus.idx;
            #1;
            bus.valid = r && i != stall_idx;
            bus.data  = (r && i < 3'd5) ? tbl[i] : 5'd0;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.req) begin
            if (iq.size() == 0) begin
                total++;
                $display("FAIL req_unexpected: got req idx %0d expected no req", bus.idx);
            end else chk("req_idx", 64'(bus.idx), 64'(iq.pop_front()));
        end
        if (done) begin
            if (sq.size() == 0) begin
                total++;
                $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sq.pop_front();
                chk("done_snap", 64'(snap), 64'(e.snap));
                chk("done_err", 64'(err), 64'(e.err));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called #1 after a clock edge; done is expected off cycles after the accept edge.
    task automatic sweep(input logic [24:0] es, input logic ee, input int off, input int nidx);
        exp_t e;
        e.snap = es;
        e.err  = ee;
        e.cyc  = cyc + 1 + off;
        sq.push_back(e);
        for (int k = 0; k < nidx; k++) iq.push_back(k);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    localparam logic [24:0] FULL = {5'd12, 5'd31, 5'd0, 5'd7, 5'd3};
    localparam logic [24:0] TOUT = {15'd0, 5'd7, 5'd3};
    localparam logic [24:0] ABRT = {20'd0, 5'd3};

    initial begin
        tbl[0] = 5'd3; tbl[1] = 5'd7; tbl[2] = 5'd0; tbl[3] = 5'd31; tbl[4] = 5'd12;
        reset = 1'b0; start = 1'b0; state = IDLE; stall_idx = 3'd7;
        #2;
        chk("rst_req", 64'(bus.req), 0);
        chk("rst_idx", 64'(bus.idx), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_snap", 64'(snap), 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        state = ACTIVE; start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("gate_busy", 64'(busy), 0);
            chk("gate_req", 64'(bus.req), 0);
        end
        @(posedge clk); #1 start = 1'b0; state = IDLE;
        sweep(FULL, 1'b0, 10, 5);
        @(negedge clk); chk("busy_cycle1", 64'(busy), 1);
        repeat (9) @(negedge clk);
        chk("busy_cycle10", 64'(busy), 1);
        @(negedge clk); chk("busy_cycle11", 64'(busy), 0);
        repeat (3) @(posedge clk); #1;
        sweep(FULL, 1'b0, 10, 5);
        repeat (4) @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk); #1;
        stall_idx = 3'd2;
        sweep(TOUT, 1'b1, 13, 3);
        repeat (14) @(posedge clk); #1;
        stall_idx = 3'd7;
        sweep(FULL, 1'b0, 10, 5);
        @(negedge clk);
        chk("b2b_snap_clear", 64'(snap), 0);
        chk("b2b_err_clear", 64'(err), 0);
        chk("b2b_busy", 64'(busy), 1);
        repeat (12) @(posedge clk); #1;
        sweep(ABRT, 1'b1, 4, 2);
        repeat (3) @(posedge clk); #1 state = ACTIVE;
        @(posedge clk); #1 state = IDLE;
        @(negedge clk); chk("abort_busy", 64'(busy), 0);
        repeat (3) @(posedge clk); #1;
        iq.push_back(0); iq.push_back(1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk); #3 reset = 1'b0;
        #1;
        chk("mid_rst_req", 64'(bus.req), 0);
        chk("mid_rst_idx", 64'(bus.idx), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_snap", 64'(snap), 0);
        chk("mid_rst_err", 64'(err), 0);
        iq.delete();
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_busy", 64'(busy), 0);
            chk("post_rst_snap", 64'(snap), 0);
            chk("post_rst_done", 64'(done), 0);
        end
        chk("pending_sweeps", 64'(sq.size()), 0);
        chk("pending_reqs", 64'(iq.size()), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
